// File: rtl/simd_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES cores.
// Define SIMD_ARB_BROADCAST_EN to serve identical reads from several cores with one RAM access.
module simd_mem_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 8,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    rvalid,
  output logic [NCORES*DW-1:0] rdata,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_wren,
  input  logic [DW-1:0]        ram_q
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

`ifdef SIMD_ARB_BROADCAST_EN
  typedef enum logic [1:0] {IDLE, SINGLE, BCAST} state_e;
`else
  typedef enum logic [1:0] {IDLE, SINGLE} state_e;
`endif

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NCORES-1:0]   gnt_q, gnt_d;
  logic [NCORES-1:0]   rd_q, rd_d;
  logic [NCORES-1:0]   rvalid_q;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       din_q, din_d;
  logic                wren_q, wren_d;

  logic [NCORES-1:0]   elig;
  logic                found_hi, found_lo;
  int                  win_hi, win_lo, win;
  logic [NCORES-1:0]   w_hot;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_data;
  logic                w_we;

  // A core is masked during its own grant cycle so it cannot be granted twice.
  assign elig = req & ~gnt_q;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = 0;
    win_lo   = 0;
    for (int i = 0; i < NCORES; i++) begin
      if (elig[i] && !found_hi && (i >= int'(ptr_q))) begin
        found_hi = 1'b1;
        win_hi   = i;
      end
      if (elig[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = i;
      end
    end
    win    = found_hi ? win_hi : win_lo;
    w_hot  = '0;
    w_addr = '0;
    w_data = '0;
    w_we   = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (i == win) begin
        w_hot[i] = 1'b1;
        w_addr   = addr[i*AW +: AW];
        w_data   = wdata[i*DW +: DW];
        w_we     = we[i];
      end
    end
  end

`ifdef SIMD_ARB_BROADCAST_EN
  int   n_el;
  logic all_rd, same_addr, bcast_ok;

  // The winner is itself eligible, so its address serves as the common reference.
  always_comb begin
    n_el      = 0;
    all_rd    = 1'b1;
    same_addr = 1'b1;
    for (int i = 0; i < NCORES; i++) begin
      if (elig[i]) begin
        n_el = n_el + 1;
        if (we[i]) all_rd = 1'b0;
        if (addr[i*AW +: AW] != w_addr) same_addr = 1'b0;
      end
    end
    bcast_ok = (n_el >= 2) && all_rd && same_addr;
  end
`endif

  always_comb begin
    state_d = IDLE;
    gnt_d   = '0;
    rd_d    = '0;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wren_d  = wren_q;
    if (elig != '0) begin
`ifdef SIMD_ARB_BROADCAST_EN
      if (bcast_ok) begin
        state_d = BCAST;
        gnt_d   = elig;
        rd_d    = elig;
        addr_d  = w_addr;
      end else
`endif
      begin
        state_d = SINGLE;
        gnt_d   = w_hot;
        rd_d    = w_we ? '0 : w_hot;
        addr_d  = w_addr;
        din_d   = w_data;
        wren_d  = w_we;
        ptr_d   = (win >= NCORES - 1) ? '0 : PW'(win + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rd_q     <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rd_q     <= rd_d;
      rvalid_q <= rd_q;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wren_q   <= wren_d;
    end
  end

  // Write strobe only during a single-core access; the stored enable is stale otherwise.
  assign ram_wren = (state_q == SINGLE) && wren_q;
  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign rdata    = {NCORES{ram_q}};

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// Bench for simd_mem_arbiter: per-cycle vector table plus hand sequences, RAM model and
// read-return scoreboard. Broadcast expectations follow SIMD_ARB_BROADCAST_EN.
module tb_simd_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  ram_addr, ram_din, ram_q;
  logic        ram_wren;

  always #5 clk = ~clk;

  simd_mem_arbiter #(.NCORES(4), .AW(8), .DW(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  typedef struct {
    logic        rstn;
    logic [3:0]  req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  gnt;
    logic [7:0]  raddr;
    logic        wren;
    logic [7:0]  din;
  } vec_t;

  typedef struct packed {
    logic [3:0] mask;
    logic [7:0] data;
  } exp_t;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  exp_t       sb[$];
  vec_t       tbl[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic logic [7:0] init_val(input int a);
    return (a == 32'h3C) ? 8'hA5 : (8'(a) ^ 8'h5A);
  endfunction

  // Synchronous single-port RAM, one cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    ram_q = '0;
    forever begin
      @(posedge clk);
      if (ram_wren) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
    end
  end

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] w,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] g,
                              input logic [7:0] ra, input logic wr, input logic [7:0] di);
    vec_t v;
    v.rstn = r; v.req = rq; v.we = w; v.addr = a; v.wdata = d;
    v.gnt = g; v.raddr = ra; v.wren = wr; v.din = di;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input string tag);
    exp_t e;
    rstn = v.rstn; req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
    if (!v.rstn && sb.size() > 0) begin
      e = sb[0];
      e.mask = '0;
      sb[0] = e;
    end
    e.mask = v.rstn ? (v.gnt & ~v.we) : 4'b0000;
    e.data = shadow[v.raddr];
    if (v.rstn && v.wren) shadow[v.raddr] = v.din;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check({tag, ".gnt"},      32'(gnt),      32'(v.gnt));
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'(v.raddr));
    check({tag, ".ram_wren"}, 32'(ram_wren), 32'(v.wren));
    check({tag, ".ram_din"},  32'(ram_din),  32'(v.din));
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.rvalid: got 0x%0h, expected no return queued", tag, rvalid);
    end else begin
      e = sb.pop_front();
      check({tag, ".rvalid"}, 32'(rvalid), 32'(e.mask));
      for (int i = 0; i < 4; i++)
        if (e.mask[i]) check($sformatf("%s.rdata%0d", tag, i), 32'(rdata[i*8 +: 8]), 32'(e.data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    sb.push_back('0);

    // Reset with everything idle
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h00, 0, 8'h00));
    // Round-robin over four continuous writers
    tbl.push_back(mk(1, 4'hF, 4'hF, 32'h43424140, 32'hD3D2D1D0, 4'h1, 8'h40, 1, 8'hD0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 32'h43424140, 32'hD3D2D1D0, 4'h2, 8'h41, 1, 8'hD1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 32'h43424140, 32'hD3D2D1D0, 4'h4, 8'h42, 1, 8'hD2));
    tbl.push_back(mk(1, 4'hF, 4'hF, 32'h43424140, 32'hD3D2D1D0, 4'h8, 8'h43, 1, 8'hD3));
    tbl.push_back(mk(1, 4'hF, 4'hF, 32'h43424140, 32'hD3D2D1D0, 4'h1, 8'h40, 1, 8'hD0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h43424140, 32'hD3D2D1D0, 4'h0, 8'h40, 0, 8'hD0));
    // Single read of core 2
    tbl.push_back(mk(1, 4'h4, 4'h0, 32'h003C0000, 32'h0, 4'h4, 8'h3C, 0, 8'h00));
    tbl.push_back(mk(1, 4'h4, 4'h0, 32'h003C0000, 32'h0, 4'h0, 8'h3C, 0, 8'h00));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h3C, 0, 8'h00));
    // Cores 0, 1, 3 read 0x10; core 2 idle with a different address
`ifdef SIMD_ARB_BROADCAST_EN
    tbl.push_back(mk(1, 4'hB, 4'h0, 32'h10991010, 32'h33221100, 4'hB, 8'h10, 0, 8'h00));
    tbl.push_back(mk(1, 4'hB, 4'h0, 32'h10991010, 32'h33221100, 4'h0, 8'h10, 0, 8'h00));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h10991010, 32'h33221100, 4'h0, 8'h10, 0, 8'h00));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h10991010, 32'h33221100, 4'h0, 8'h10, 0, 8'h00));
`else
    tbl.push_back(mk(1, 4'hB, 4'h0, 32'h10991010, 32'h33221100, 4'h8, 8'h10, 0, 8'h33));
    tbl.push_back(mk(1, 4'hB, 4'h0, 32'h10991010, 32'h33221100, 4'h1, 8'h10, 0, 8'h00));
    tbl.push_back(mk(1, 4'h3, 4'h0, 32'h10991010, 32'h33221100, 4'h2, 8'h10, 0, 8'h11));
    tbl.push_back(mk(1, 4'h2, 4'h0, 32'h10991010, 32'h33221100, 4'h0, 8'h10, 0, 8'h11));
`endif
    // Read and write to the same address: no broadcast, read sees old then new data
    tbl.push_back(mk(1, 4'h3, 4'h2, 32'h00002020, 32'h00007700, 4'h1, 8'h20, 0, 8'h00));
    tbl.push_back(mk(1, 4'h3, 4'h2, 32'h00002020, 32'h00007700, 4'h2, 8'h20, 1, 8'h77));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h00002020, 32'h00007700, 4'h0, 8'h20, 0, 8'h77));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h00000020, 32'h0, 4'h1, 8'h20, 0, 8'h00));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h00000020, 32'h0, 4'h0, 8'h20, 0, 8'h00));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h20, 0, 8'h00));

    for (int r = 0; r < tbl.size(); r++) begin
      run_cycle(tbl[r], $sformatf("row%0d", r));
      if (r == 1) check("ptr_after_reset", 32'(dut.ptr_q), 32'h0);
    end

    // Reset in the cycle after core 0's read grant: the return is lost
    run_cycle(mk(1, 4'h1, 4'h0, 32'h0000003C, 32'h0, 4'h1, 8'h3C, 0, 8'h00), "midrst0");
    run_cycle(mk(0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h00, 0, 8'h00), "midrst1");
    check("ptr_mid_reset", 32'(dut.ptr_q), 32'h0);
    run_cycle(mk(1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h00, 0, 8'h00), "midrst2");
    // Pointer back at 0: core 0 must beat core 3
    run_cycle(mk(1, 4'h9, 4'h0, 32'h42000041, 32'h0, 4'h1, 8'h41, 0, 8'h00), "resume0");
    run_cycle(mk(1, 4'h9, 4'h0, 32'h42000041, 32'h0, 4'h8, 8'h42, 0, 8'h00), "resume1");
    run_cycle(mk(1, 4'h8, 4'h0, 32'h42000041, 32'h0, 4'h0, 8'h42, 0, 8'h00), "resume2");
    run_cycle(mk(1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 8'h42, 0, 8'h00), "resume3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_mem_arbiter.md
# simd_mem_arbiter

Parametrised arbiter that lets NCORES processing cores share one single-port synchronous RAM. Each core has its own request/grant handshake. A round-robin policy guarantees fairness, and an optional broadcast mode serves identical reads from all requesters with a single RAM access. It sits between the SIMD core array and the shared data RAM, and replaces the fixed 4-core, fixed-priority arbiter generation.

## Interface

Parameters:
- `NCORES`, 4: number of requesting cores (≥2).
- `AW`, 8: RAM address width.
- `DW`, 8: RAM data width.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rstn`, in, 1: synchronous, active-low reset.
- `req`, in, NCORES: per-core access request; held high until granted.
- `we`, in, NCORES: per-core write enable; qualifies `req`.
- `addr`, in, NCORES*AW: per-core address; core i occupies `[i*AW +: AW]`.
- `wdata`, in, NCORES*DW: per-core write data; core i occupies `[i*DW +: DW]`.
- `gnt`, out, NCORES: one-cycle grant pulse per core.
- `rvalid`, out, NCORES: read data valid for core i.
- `rdata`, out, NCORES*DW: per-core read data; every slice equals `ram_q`.
- `ram_addr`, out, AW: registered RAM address.
- `ram_din`, out, DW: registered RAM write data.
- `ram_wren`, out, 1: registered RAM write enable.
- `ram_q`, in, DW: RAM read data, valid one cycle after the address is presented.

## Operation

Eligibility:
- Eligible set is `E = req & ~gnt`.
- Masking cores with `gnt` already high prevents re-granting a core during its grant cycle.

Arbitration FSM: states IDLE, SINGLE, BCAST. The state describes the access being issued in the current cycle; the next state is evaluated every edge.
- **BCAST**: chosen when all of the following hold:
  - broadcast is compiled in;
  - `popcount(E) ≥ 2`;
  - every core in E has `we=0`;
  - every core in E has an identical address.
  
  Effects: `gnt = E`; `ram_addr` is the common address; `ram_wren=0`; the round-robin pointer is unchanged.
- **SINGLE**: chosen when E is non-empty and the BCAST conditions fail.
  - Winner is the first set bit of E scanning from pointer `ptr` upward, wrapping NCORES-1 → 0.
  - `gnt` is one-hot on the winner; `ram_addr`, `ram_din` and `ram_wren` take the winner's `addr`, `wdata` and `we`.
  - `ptr` becomes `(winner+1) mod NCORES`.
- **IDLE**: chosen when E is empty. `gnt=0`, `ram_wren=0`, and `ram_addr`/`ram_din` hold their previous values.

Read return:
- The granted read mask is delayed one cycle to drive `rvalid`.
- `rdata` slices are wired directly to `ram_q`.
- Writes never produce `rvalid`.

Address comparison:
- Compares only cores in E; non-requesting cores' addresses are ignored.
- Compares the full AW bits.

## Timing

- Reset (`rstn=0` at an edge): state=IDLE, `ptr=0`, `gnt=0`, `rvalid=0`, `ram_addr=0`, `ram_din=0`, `ram_wren=0`.
- Request-to-grant latency:
  - `req` high in cycle t with no contention gives `gnt` and `ram_*` in t+1.
  - Read data arrives with `rvalid` in t+2.
  - A write completes at the end of t+1.
- Handshake:
  - A core samples `gnt` and may drop `req` or change `addr`/`we`/`wdata` from the following edge.
  - A core must hold `addr`/`we`/`wdata` stable while `req` is high and ungranted.
  - Dropping `req` before grant is allowed; the request is then lost.
- Throughput:
  - One RAM access per cycle.
  - The same core can be granted at most every second cycle.
  - Different cores can be granted back-to-back.
- Worst-case wait: NCORES-1 grant slots for a core continuously requesting under round-robin.
- Simultaneous read and write to the same address by different cores: no broadcast; served in round-robin order. A read issued after the write returns the new data.
- Reset mid-operation: pending `rvalid` is cleared and the read is lost; cores must reissue after `rstn` rises.

## Configuration

- `SIMD_ARB_BROADCAST_EN` defined: BCAST state and address comparator are compiled in, with behaviour as above.
- Macro undefined: BCAST state is absent. Every access goes through SINGLE round-robin; identical reads from N cores take N grant cycles.

## Test plan

- Reset, then idle: with `rstn=0` for 2 cycles and all `req=0`, every output stays 0 and `ptr=0`.
- Single read: core 2 reads `addr=0x3C` with RAM holding 0xA5 → `gnt=0100` in t+1, `ram_addr=0x3C`, `ram_wren=0`; in t+2 `rvalid=0100` and `rdata` slice 2 = 0xA5.
- Round-robin fairness: all 4 cores hold write requests to distinct addresses → grant order 0,1,2,3, then 0 again, one per cycle; `ram_wren=1` each cycle with the matching `ram_din`.
- Broadcast (macro defined): cores 0, 1 and 3 read 0x10 and core 2 is idle → a single cycle with `gnt=1011` and `ram_addr=0x10`; the next cycle has `rvalid=1011`. With the macro undefined, the same stimulus yields three one-hot grants 0, 1, 3.
- Broadcast blocked by a write: cores 0 and 1 target 0x20, and core 1 has `we=1` with `wdata=0x77` → SINGLE grants to core 0 (read, returns old data) then core 1 (write). A following read by core 0 returns 0x77.
- Reset mid-read: `rstn` is pulled low in the cycle after core 0's grant → `rvalid` stays 0, `ptr=0`, and normal operation resumes after `rstn=1`.
